alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters, e.g. the execute stage (port 0) and a branch/address-calculation unit (port 1).
- Uses round-robin arbitration with valid/ready handshakes on both request and response sides.
- Registers the operands, drives the ALU for one cycle, then captures the result and flags into a response register held until the response is consumed.
- Keeps one operation outstanding at a time.

---
 rtl/alu_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters. Arbitration is
// round-robin, and only one operation is in flight at a time. The accepted
// operands are registered toward the ALU, and the ALU output is captured one
// cycle later into the response register of the port that issued the request.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake, N = 0, 1
//   reqN_a, reqN_b, reqN_op     request payload
//   alu_a, alu_b, alu_op        registered operands driven to the shared ALU
//   alu_result, alu_overflow,
//   alu_carryout, alu_zero      ALU outputs, sampled in EXEC
//   rspN_valid/ready            response handshake
//   rspN_result, rspN_flags     captured result and {overflow, carryout, zero}
//
// state | meaning
// IDLE  | no operation in flight; arbitrate and accept one request
// EXEC  | ALU inputs stable; capture ALU outputs at the end of this cycle
// RESP  | response held on the tagged port until it is consumed
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [OP_WIDTH-1:0]   req1_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow,
  input  logic                  alu_carryout,
  input  logic                  alu_zero,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic [2:0]            rsp0_flags,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic [2:0]            rsp1_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   tag;

  logic   grant_any;
  logic   grant_port;
  logic   accept;
  logic   rsp_done;

  // On a tie the port that did not win last time is chosen; with a single
  // requester that requester wins regardless of history.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_port = ~last_grant;
    end else begin
      grant_port = ~req0_valid;
    end
  end

  assign req0_ready = (state == IDLE) & grant_any & ~grant_port;
  assign req1_ready = (state == IDLE) & grant_any &  grant_port;

  assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // Only the tagged port can hold a valid response, so a ready on the other
  // port never completes the transaction.
  assign rsp_done = (state == RESP) &
                    (tag ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      tag         <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_flags  <= '0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= grant_port ? req1_a  : req0_a;
            alu_b      <= grant_port ? req1_b  : req0_b;
            alu_op     <= grant_port ? req1_op : req0_op;
            tag        <= grant_port;
            last_grant <= grant_port;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (tag) begin
            rsp1_result <= alu_result;
            rsp1_flags  <= {alu_overflow, alu_carryout, alu_zero};
            rsp1_valid  <= 1'b1;
          end else begin
            rsp0_result <= alu_result;
            rsp0_flags  <= {alu_overflow, alu_carryout, alu_zero};
            rsp0_valid  <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Directed scenarios followed by a randomized phase for alu_share_arbiter.
// A behavioural ALU drives the DUT's ALU inputs. A transaction-level model
// tracks which request is in flight, and from that it predicts ready,
// response timing, and the payload of each response.
module tb_alu_share_arbiter;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1001;
  localparam logic [3:0] OP_SLL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_SRL = 4'b1100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_overflow, alu_carryout, alu_zero;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [2:0]  rsp0_flags, rsp1_flags;

  alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_carryout(alu_carryout), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags)
  );

  always #5 clk = ~clk;

  // Returns {overflow, carryout, zero, result}.
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic ov, co, z;
    r = '0; ov = 1'b0; co = 1'b0; z = 1'b0; s = '0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_ADD: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
        z  = (r == 32'd0);
      end
      OP_SUB: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
        z  = (r == 32'd0);
      end
      OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLL: r = b << a[4:0];
      OP_SRA: r = $signed(b) >>> a[4:0];
      OP_SRL: r = b >> a[4:0];
      default: r = '0;
    endcase
    return {ov, co, z, r};
  endfunction

  always_comb begin : alu_model
    logic [34:0] t;
    t = alu_f(alu_a, alu_b, alu_op);
    {alu_overflow, alu_carryout, alu_zero} = t[34:32];
    alu_result = t[31:0];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transaction-level model state
  bit          busy;
  int          acc_cyc, m_port, last_port, cyc, hs_cyc;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [34:0] m_rsp;
  bit          acc0_now, acc1_now;
  int          acc_ports[$];
  int          acc_cycs[$];
  logic [31:0] last_rsp0, last_rsp1;

  task automatic model_reset();
    busy = 1'b0; last_port = 1; m_a = '0; m_b = '0; m_op = '0;
    acc0_now = 1'b0; acc1_now = 1'b0;
  endtask

  // Inputs for this cycle are already applied (posedge+1). Check at the
  // falling edge, advance the model, and return at the next posedge+1.
  task automatic tick();
    bit any, r0e, r1e, v0e, v1e;
    int gp;
    @(negedge clk);
    any = req0_valid || req1_valid;
    gp  = (req0_valid && req1_valid) ? 1 - last_port : (req0_valid ? 0 : 1);
    r0e = !busy && any && gp == 0;
    r1e = !busy && any && gp == 1;
    v0e = busy && m_port == 0 && cyc >= acc_cyc + 2;
    v1e = busy && m_port == 1 && cyc >= acc_cyc + 2;
    chk("req0_ready", 32'(req0_ready), 32'(r0e));
    chk("req1_ready", 32'(req1_ready), 32'(r1e));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(v0e));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(v1e));
    if (v0e) begin
      chk("rsp0_result", rsp0_result, m_rsp[31:0]);
      chk("rsp0_flags", 32'(rsp0_flags), 32'(m_rsp[34:32]));
    end
    if (v1e) begin
      chk("rsp1_result", rsp1_result, m_rsp[31:0]);
      chk("rsp1_flags", 32'(rsp1_flags), 32'(m_rsp[34:32]));
    end
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", 32'(alu_op), 32'(m_op));
    acc0_now = 1'b0; acc1_now = 1'b0;
    if (v0e && rsp0_ready) begin busy = 1'b0; hs_cyc = cyc; last_rsp0 = rsp0_result; end
    if (v1e && rsp1_ready) begin busy = 1'b0; hs_cyc = cyc; last_rsp1 = rsp1_result; end
    if (r0e || r1e) begin
      busy = 1'b1; acc_cyc = cyc; m_port = gp; last_port = gp;
      m_a  = r0e ? req0_a  : req1_a;
      m_b  = r0e ? req0_b  : req1_b;
      m_op = r0e ? req0_op : req1_op;
      m_rsp = alu_f(m_a, m_b, m_op);
      acc0_now = r0e; acc1_now = r1e;
      acc_ports.push_back(gp);
      acc_cycs.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    resetn = 1'b0;
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    cyc = 0; acc_cyc = 0; m_port = 0; hs_cyc = 0;
    last_rsp0 = '0; last_rsp1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    resetn = 1'b1;
    tick(); tick();

    // Single ADD on port 0 with signed overflow
    set0(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
    tick();
    chk("add_accept", 32'(acc0_now), 32'd1);
    req0_valid = 1'b0;
    chk("add_alu_a", alu_a, 32'h7FFF_FFFF);
    chk("add_alu_op", 32'(alu_op), 32'(OP_ADD));
    tick();
    chk("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("add_result", rsp0_result, 32'h8000_0000);
    chk("add_flags", 32'(rsp0_flags), 32'b100);
    chk("add_rsp1_quiet", 32'(rsp1_valid), 32'd0);
    tick();

    // Zero flag on SUB, none on OR
    set1(1'b1, 32'd5, 32'd5, OP_SUB);
    tick(); req1_valid = 1'b0; tick();
    chk("sub_result", rsp1_result, 32'd0);
    chk("sub_zero", 32'(rsp1_flags[0]), 32'd1);
    tick();
    set1(1'b1, 32'd0, 32'd0, OP_OR);
    tick(); req1_valid = 1'b0; tick();
    chk("or_result", rsp1_result, 32'd0);
    chk("or_flags", 32'(rsp1_flags), 32'd0);
    tick();

    // Port 1 raises a request while port 0 is in flight
    set0(1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF, OP_AND);
    tick(); req0_valid = 1'b0;
    set1(1'b1, 32'd0, 32'd0, OP_NOR);
    tick(); tick();
    chk("held_hs_cycle", 32'(hs_cyc), 32'(cyc - 1));
    tick();
    chk("held_accept", 32'(acc1_now), 32'd1);
    req1_valid = 1'b0;
    tick();
    chk("nor_result", rsp1_result, 32'hFFFF_FFFF);
    tick();

    // Backpressure on port 0 while port 1 waits
    rsp0_ready = 1'b0;
    set0(1'b1, 32'd100, 32'd23, OP_SUB);
    tick(); req0_valid = 1'b0;
    set1(1'b1, 32'h0000_FFFF, 32'hFFFF_0000, OP_XOR);
    tick();
    repeat (5) tick();
    chk("bp_result_held", rsp0_result, 32'd77);
    chk("bp_req1_blocked", 32'(req1_ready), 32'd0);
    rsp0_ready = 1'b1;
    tick();
    tick();
    chk("bp_accept_after_hs", 32'(acc1_now), 32'd1);
    chk("bp_gap", 32'(acc_cyc - hs_cyc), 32'd1);
    req1_valid = 1'b0;
    tick(); tick(); tick();

    // Reset during EXEC of a port 1 XOR
    set1(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, OP_XOR);
    tick(); req1_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("mid_rst_rsp1_result", rsp1_result, 32'd0);
    tick(); tick();
    resetn = 1'b1;

    // Continuous tie from reset: grants alternate, accepts 3 cycles apart
    set0(1'b1, 32'd4, 32'd1, OP_SLL);
    set1(1'b1, 32'd4, 32'h8000_0000, OP_SRA);
    #1;
    chk("tie_first_grant0", 32'(req0_ready), 32'd1);
    base = acc_ports.size();
    repeat (13) tick();
    chk("tie_n_accepts", 32'(acc_ports.size() - base), 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie_grant%0d", i), 32'(acc_ports[base + i]), 32'(i % 2));
      chk($sformatf("tie_gap%0d", i), 32'(acc_cycs[base + i + 1] - acc_cycs[base + i]), 32'd3);
    end
    chk("tie_rsp0", last_rsp0, 32'h0000_0010);
    chk("tie_rsp1", last_rsp1, 32'hF800_0000);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick(); tick();

    // Randomized traffic, requesters hold valid/payload until accepted
    repeat (400) begin
      if (!(req0_valid && !acc0_now))
        set0(1'($urandom_range(0, 2) != 0), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (!(req1_valid && !acc1_now))
        set1(1'($urandom_range(0, 2) != 0), $urandom, $urandom, 4'($urandom_range(0, 15)));
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      tick();
    end
    if (acc0_now) req0_valid = 1'b0;
    if (acc1_now) req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (12) begin
      tick();
      if (acc0_now) req0_valid = 1'b0;
      if (acc1_now) req1_valid = 1'b0;
    end
    chk("drain_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
